adxl_spi3w_responder: RTL and testbench

- Synthesizable responder for the 3-wire SPI accelerometer bus: SDAT, SCLK, CS_N, INT. It behaves like the on-board g-sensor as seen from the Nios SPI master.
- Used for hardware-in-loop and regression. Fabric logic supplies X/Y/Z samples; the master reads them over SPI exactly as it would read the real sensor.
- Oversamples SCLK and CS_N in the system clock domain and implements a reduced ADXL-style register map.

---
 rtl/adxl_resp_pkg.sv | 33 +++
 rtl/adxl_spi3w_responder_sync.sv | 41 ++++
 rtl/adxl_spi3w_responder.sv | 261 ++++++++++++++++++++++++++
 tb/tb_adxl_spi3w_responder.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adxl_resp_pkg.sv
// Shared definitions for the 3-wire SPI accelerometer responder.
// This file holds the register addresses, the bit positions and the frame FSM states.
package adxl_resp_pkg;

  localparam logic [5:0] ADDR_DEVID       = 6'h00;
  localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
  localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
  localparam logic [5:0] ADDR_INT_ENABLE  = 6'h2E;
  localparam logic [5:0] ADDR_INT_SOURCE  = 6'h30;
  localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
  localparam logic [5:0] ADDR_DATAX0      = 6'h32;
  localparam logic [5:0] ADDR_DATAX1      = 6'h33;
  localparam logic [5:0] ADDR_DATAY0      = 6'h34;
  localparam logic [5:0] ADDR_DATAY1      = 6'h35;
  localparam logic [5:0] ADDR_DATAZ0      = 6'h36;
  localparam logic [5:0] ADDR_DATAZ1      = 6'h37;

  localparam int DATA_READY_BIT = 7;
  localparam int INT_INVERT_BIT = 5;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_CS_HIGH,
    CMD,
    WR,
    RD
  } state_e;

  function automatic logic is_data_addr(input logic [5:0] a);
    return (a >= ADDR_DATAX0) && (a <= ADDR_DATAZ1);
  endfunction

endpackage

// File: rtl/adxl_spi3w_responder_sync.sv
// This module synchronizes SCLK, CS_N and SDAT into the clk domain and detects edges.
// Its outputs are one-cycle rise/fall strobes plus the synchronized levels.
module spi3w_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic sclk_i,
  input  logic cs_n_i,
  input  logic sdat_i,
  output logic sclk_rise_o,
  output logic sclk_fall_o,
  output logic cs_fall_o,
  output logic cs_rise_o,
  output logic cs_lvl_o,
  output logic sdat_s_o
);

  logic [SYNC_STAGES-1:0] sclk_sq;
  logic [SYNC_STAGES-1:0] cs_sq;
  logic [SYNC_STAGES-1:0] sdat_sq;
  logic                   sclk_prev_q;
  logic                   cs_prev_q;

  // The chains are deliberately not reset. They keep tracking the pads during
  // reset, so releasing reset while CS_N is low cannot fake a CS_N falling edge.
  always_ff @(posedge clk_i) begin
    sclk_sq     <= {sclk_sq[SYNC_STAGES-2:0], sclk_i};
    cs_sq       <= {cs_sq[SYNC_STAGES-2:0], cs_n_i};
    sdat_sq     <= {sdat_sq[SYNC_STAGES-2:0], sdat_i};
    sclk_prev_q <= sclk_sq[SYNC_STAGES-1];
    cs_prev_q   <= cs_sq[SYNC_STAGES-1];
  end

  assign sclk_rise_o = ~sclk_prev_q &  sclk_sq[SYNC_STAGES-1];
  assign sclk_fall_o =  sclk_prev_q & ~sclk_sq[SYNC_STAGES-1];
  assign cs_rise_o   = ~cs_prev_q   &  cs_sq[SYNC_STAGES-1];
  assign cs_fall_o   =  cs_prev_q   & ~cs_sq[SYNC_STAGES-1];
  assign cs_lvl_o    =  cs_sq[SYNC_STAGES-1];
  assign sdat_s_o    =  sdat_sq[SYNC_STAGES-1];

endmodule

// File: rtl/adxl_spi3w_responder.sv
// This module is an ADXL-style 3-wire SPI responder with a reduced register map.
// Fabric samples are captured here, and a Nios SPI master reads them over the bus.
module adxl_spi3w_responder
  import adxl_resp_pkg::*;
#(
  parameter logic [7:0] DEVID       = 8'hE5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_sdat_i,
  output logic        spi_sdat_o,
  output logic        spi_sdat_oe,
  output logic        spi_int,
  input  logic        sample_valid,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic [15:0] sample_z
);

  logic sclk_rise, sclk_fall, cs_fall, cs_rise, cs_lvl, sdat_s;

  spi3w_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_i       (clk_clk),
    .sclk_i      (spi_sclk),
    .cs_n_i      (spi_cs_n),
    .sdat_i      (spi_sdat_i),
    .sclk_rise_o (sclk_rise),
    .sclk_fall_o (sclk_fall),
    .cs_fall_o   (cs_fall),
    .cs_rise_o   (cs_rise),
    .cs_lvl_o    (cs_lvl),
    .sdat_s_o    (sdat_s)
  );

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]  tx_cnt_q, tx_cnt_d;
  logic [6:0]  rx_q, rx_d;
  logic [7:0]  tx_q, tx_d;
  logic        mb_q, mb_d;
  logic [5:0]  addr_q, addr_d;
  logic        sdat_o_q, sdat_o_d;
  logic        sdat_oe_q, sdat_oe_d;
  logic        int_q, int_d;
  logic [7:0]  bw_rate_q, bw_rate_d;
  logic [7:0]  power_ctl_q, power_ctl_d;
  logic [7:0]  int_enable_q, int_enable_d;
  logic [7:0]  data_format_q, data_format_d;
  logic [15:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [15:0] pend_x_q, pend_x_d, pend_y_q, pend_y_d, pend_z_q, pend_z_d;
  logic        pend_vld_q, pend_vld_d;
  logic        data_ready_q, data_ready_d;
  logic        rd_data_q, rd_data_d;

  logic [7:0]  rx_byte;
  logic [7:0]  rd_byte;
  logic [5:0]  addr_nxt;
  logic        busy;

  always_comb begin
    rd_byte = 8'h00;
    case (addr_q)
      ADDR_DEVID:       rd_byte = DEVID;
      ADDR_BW_RATE:     rd_byte = bw_rate_q;
      ADDR_POWER_CTL:   rd_byte = power_ctl_q;
      ADDR_INT_ENABLE:  rd_byte = int_enable_q;
      ADDR_INT_SOURCE:  rd_byte[DATA_READY_BIT] = data_ready_q;
      ADDR_DATA_FORMAT: rd_byte = data_format_q;
      ADDR_DATAX0:      rd_byte = x_q[7:0];
      ADDR_DATAX1:      rd_byte = x_q[15:8];
      ADDR_DATAY0:      rd_byte = y_q[7:0];
      ADDR_DATAY1:      rd_byte = y_q[15:8];
      ADDR_DATAZ0:      rd_byte = z_q[7:0];
      ADDR_DATAZ1:      rd_byte = z_q[15:8];
      default:          rd_byte = 8'h00;
    endcase
  end

  assign rx_byte  = {rx_q, sdat_s};
  assign addr_nxt = mb_q ? addr_q + 6'd1 : addr_q;
  // A read frame that has touched, or is about to touch, the data registers
  // must see one coherent sample, so new samples are parked until CS_N rises.
  assign busy     = (state_q == RD) && (rd_data_q || is_data_addr(addr_q));

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    tx_cnt_d      = tx_cnt_q;
    rx_d          = rx_q;
    tx_d          = tx_q;
    mb_d          = mb_q;
    addr_d        = addr_q;
    sdat_o_d      = sdat_o_q;
    sdat_oe_d     = sdat_oe_q;
    bw_rate_d     = bw_rate_q;
    power_ctl_d   = power_ctl_q;
    int_enable_d  = int_enable_q;
    data_format_d = data_format_q;
    x_d           = x_q;
    y_d           = y_q;
    z_d           = z_q;
    pend_x_d      = pend_x_q;
    pend_y_d      = pend_y_q;
    pend_z_d      = pend_z_q;
    pend_vld_d    = pend_vld_q;
    data_ready_d  = data_ready_q;
    rd_data_d     = rd_data_q;

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d   = CMD;
          bit_cnt_d = 3'd0;
        end else if (!cs_lvl) begin
          state_d = WAIT_CS_HIGH;
        end
      end
      WAIT_CS_HIGH: begin
        if (cs_lvl) state_d = IDLE;
      end
      CMD: begin
        if (sclk_rise) begin
          rx_d      = rx_byte[6:0];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            mb_d      = rx_byte[6];
            addr_d    = rx_byte[5:0];
            tx_cnt_d  = 3'd7;
            rd_data_d = 1'b0;
            state_d   = rx_byte[7] ? RD : WR;
          end
        end
      end
      WR: begin
        if (sclk_rise) begin
          rx_d      = rx_byte[6:0];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            case (addr_q)
              ADDR_BW_RATE:     bw_rate_d     = rx_byte;
              ADDR_POWER_CTL:   power_ctl_d   = rx_byte;
              ADDR_INT_ENABLE:  int_enable_d  = rx_byte;
              ADDR_DATA_FORMAT: data_format_d = rx_byte;
              default: ;
            endcase
            addr_d = addr_nxt;
          end
        end
      end
      RD: begin
        // tx_cnt_q == 7 means the previous byte is exhausted (or none loaded yet).
        if (sclk_fall) begin
          if (tx_cnt_q == 3'd7) begin
            sdat_o_d  = rd_byte[7];
            tx_d      = {rd_byte[6:0], 1'b0};
            tx_cnt_d  = 3'd0;
            sdat_oe_d = 1'b1;
            addr_d    = addr_nxt;
            if (is_data_addr(addr_q)) rd_data_d = 1'b1;
          end else begin
            sdat_o_d = tx_q[7];
            tx_d     = {tx_q[6:0], 1'b0};
            tx_cnt_d = tx_cnt_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (cs_rise) begin
      state_d   = IDLE;
      sdat_oe_d = 1'b0;
      sdat_o_d  = 1'b0;
      rd_data_d = 1'b0;
    end

    // A new sample has priority over the pending buffer. Setting DATA_READY has priority over clearing it.
    if (sample_valid && (!busy || cs_rise)) begin
      x_d          = sample_x;
      y_d          = sample_y;
      z_d          = sample_z;
      data_ready_d = 1'b1;
      pend_vld_d   = 1'b0;
    end else if (sample_valid) begin
      pend_x_d   = sample_x;
      pend_y_d   = sample_y;
      pend_z_d   = sample_z;
      pend_vld_d = 1'b1;
    end else if (cs_rise && pend_vld_q) begin
      x_d          = pend_x_q;
      y_d          = pend_y_q;
      z_d          = pend_z_q;
      data_ready_d = 1'b1;
      pend_vld_d   = 1'b0;
    end else if (cs_rise && rd_data_q) begin
      data_ready_d = 1'b0;
    end

    int_d = (data_ready_q & int_enable_q[DATA_READY_BIT]) ^ data_format_q[INT_INVERT_BIT];
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q       <= IDLE;
      bit_cnt_q     <= 3'd0;
      tx_cnt_q      <= 3'd7;
      rx_q          <= 7'd0;
      tx_q          <= 8'd0;
      mb_q          <= 1'b0;
      addr_q        <= 6'd0;
      sdat_o_q      <= 1'b0;
      sdat_oe_q     <= 1'b0;
      int_q         <= 1'b0;
      bw_rate_q     <= 8'd0;
      power_ctl_q   <= 8'd0;
      int_enable_q  <= 8'd0;
      data_format_q <= 8'd0;
      x_q           <= 16'd0;
      y_q           <= 16'd0;
      z_q           <= 16'd0;
      pend_x_q      <= 16'd0;
      pend_y_q      <= 16'd0;
      pend_z_q      <= 16'd0;
      pend_vld_q    <= 1'b0;
      data_ready_q  <= 1'b0;
      rd_data_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      tx_cnt_q      <= tx_cnt_d;
      rx_q          <= rx_d;
      tx_q          <= tx_d;
      mb_q          <= mb_d;
      addr_q        <= addr_d;
      sdat_o_q      <= sdat_o_d;
      sdat_oe_q     <= sdat_oe_d;
      int_q         <= int_d;
      bw_rate_q     <= bw_rate_d;
      power_ctl_q   <= power_ctl_d;
      int_enable_q  <= int_enable_d;
      data_format_q <= data_format_d;
      x_q           <= x_d;
      y_q           <= y_d;
      z_q           <= z_d;
      pend_x_q      <= pend_x_d;
      pend_y_q      <= pend_y_d;
      pend_z_q      <= pend_z_d;
      pend_vld_q    <= pend_vld_d;
      data_ready_q  <= data_ready_d;
      rd_data_q     <= rd_data_d;
    end
  end

  assign spi_sdat_o  = sdat_o_q;
  assign spi_sdat_oe = sdat_oe_q;
  assign spi_int     = int_q;

endmodule

// File: tb/tb_adxl_spi3w_responder.sv
// Scoreboard bench for adxl_spi3w_responder: a mode-3 SPI master, a register-map
// model, and a forked monitor that reassembles read bytes and compares them.
module tb_adxl_spi3w_responder;

  localparam int HALF = 5;

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic        spi_sclk, spi_cs_n, spi_sdat_i;
  logic        spi_sdat_o, spi_sdat_oe, spi_int;
  logic        sample_valid;
  logic [15:0] sample_x, sample_y, sample_z;

  always #10 clk_clk = ~clk_clk;

  adxl_spi3w_responder dut (
    .clk_clk      (clk_clk),
    .reset_reset  (reset_reset),
    .spi_sclk     (spi_sclk),
    .spi_cs_n     (spi_cs_n),
    .spi_sdat_i   (spi_sdat_i),
    .spi_sdat_o   (spi_sdat_o),
    .spi_sdat_oe  (spi_sdat_oe),
    .spi_int      (spi_int),
    .sample_valid (sample_valid),
    .sample_x     (sample_x),
    .sample_y     (sample_y),
    .sample_z     (sample_z)
  );

  int errors = 0;
  int checks = 0;
  int oe_bad = 0;
  bit rd_phase = 1'b0;
  bit cmd_phase = 1'b0;
  logic [7:0] exp_q[$];

  logic [7:0]  m_reg[64];
  logic [15:0] m_x, m_y, m_z;
  bit          m_dr;

  function automatic logic [7:0] m_byte(input logic [5:0] a);
    case (a)
      6'h00: return 8'hE5;
      6'h2C, 6'h2D, 6'h2E, 6'h31: return m_reg[a];
      6'h30: return {m_dr, 7'b0};
      6'h32: return m_x[7:0];
      6'h33: return m_x[15:8];
      6'h34: return m_y[7:0];
      6'h35: return m_y[15:8];
      6'h36: return m_z[7:0];
      6'h37: return m_z[15:8];
      default: return 8'h00;
    endcase
  endfunction

  function automatic bit m_writable(input logic [5:0] a);
    return (a == 6'h2C) || (a == 6'h2D) || (a == 6'h2E) || (a == 6'h31);
  endfunction

  function automatic logic m_int();
    logic [7:0] ie, df;
    ie = m_reg[6'h2E];
    df = m_reg[6'h31];
    return (m_dr & ie[7]) ^ df[5];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 64; i++) m_reg[i] = 8'h00;
    m_x = 16'h0; m_y = 16'h0; m_z = 16'h0; m_dr = 1'b0;
  endtask

  task automatic m_apply(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    m_x = x; m_y = y; m_z = z; m_dr = 1'b1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    logic [7:0] sh = 8'h00;
    logic [7:0] e;
    int nb = 0;
    bit oe_all = 1'b1;
    forever begin
      @(posedge spi_sclk);
      if (spi_cs_n) continue;
      if (cmd_phase && spi_sdat_oe) oe_bad++;
      if (rd_phase) begin
        sh = {sh[6:0], spi_sdat_o};
        oe_all = oe_all & spi_sdat_oe;
        nb++;
        if (nb == 8) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rd_byte: got %02h but no byte was expected", sh);
          end else begin
            e = exp_q.pop_front();
            if (sh !== e || !oe_all) begin
              errors++;
              $display("FAIL rd_byte: got %02h oe=%0b expected %02h oe=1", sh, oe_all, e);
            end
          end
          nb = 0;
          oe_all = 1'b1;
        end
      end
    end
  endtask

  task automatic half_p();
    repeat (HALF) @(negedge clk_clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input int nb);
    for (int i = 0; i < nb; i++) begin
      spi_sclk = 1'b0;
      spi_sdat_i = b[7-i];
      half_p();
      spi_sclk = 1'b1;
      half_p();
    end
  endtask

  task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    @(negedge clk_clk);
    sample_valid = 1'b1; sample_x = x; sample_y = y; sample_z = z;
    @(negedge clk_clk);
    sample_valid = 1'b0;
  endtask

  task automatic do_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    pulse_sample(x, y, z);
    m_apply(x, y, z);
    @(negedge clk_clk);
    check("int_after_sample", 32'(spi_int), 32'(m_int()));
  endtask

  task automatic end_frame();
    half_p();
    spi_cs_n = 1'b1;
    repeat (6) @(negedge clk_clk);
    check("oe_after_cs_rise", 32'(spi_sdat_oe), 32'd0);
    check("oe_outside_data", 32'(oe_bad), 32'd0);
    oe_bad = 0;
  endtask

  task automatic write_frame(input logic [5:0] a, input logic [7:0] d, input int nb = 8);
    spi_cs_n = 1'b0;
    cmd_phase = 1'b1;
    half_p();
    send_bits({2'b00, a}, 8);
    send_bits(d, nb);
    cmd_phase = 1'b0;
    end_frame();
    if (nb == 8 && m_writable(a)) m_reg[a] = d;
    check("int_after_write", 32'(spi_int), 32'(m_int()));
  endtask

  task automatic read_frame(input logic [5:0] a, input bit mb, input int n, input int inj_bit = -1,
                            input logic [15:0] ix = 16'h0, input logic [15:0] iy = 16'h0,
                            input logic [15:0] iz = 16'h0);
    logic [5:0] ad;
    bit touched, pend;
    ad = a; touched = 1'b0; pend = 1'b0;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(m_byte(ad));
      if (ad >= 6'h32 && ad <= 6'h37) touched = 1'b1;
      if (mb) ad = ad + 6'd1;
    end
    spi_cs_n = 1'b0;
    cmd_phase = 1'b1;
    half_p();
    send_bits({1'b1, mb, a}, 8);
    cmd_phase = 1'b0;
    rd_phase = 1'b1;
    for (int b = 0; b < n * 8; b++) begin
      if (b == inj_bit) begin
        pulse_sample(ix, iy, iz);
        pend = 1'b1;
      end
      spi_sclk = 1'b0;
      half_p();
      spi_sclk = 1'b1;
      half_p();
    end
    rd_phase = 1'b0;
    end_frame();
    check("bytes_outstanding", 32'(exp_q.size()), 32'd0);
    if (pend) m_apply(ix, iy, iz);
    else if (touched) m_dr = 1'b0;
    check("int_after_read", 32'(spi_int), 32'(m_int()));
  endtask

  initial begin
    logic [5:0] wa_list[7];
    logic [5:0] ra;
    int op, n, nb;
    wa_list = '{6'h2C, 6'h2D, 6'h2E, 6'h31, 6'h32, 6'h00, 6'h3F};

    reset_reset = 1'b1;
    spi_sclk = 1'b1; spi_cs_n = 1'b1; spi_sdat_i = 1'b0;
    sample_valid = 1'b0; sample_x = 16'h0; sample_y = 16'h0; sample_z = 16'h0;
    m_reset();
    fork
      monitor();
    join_none
    repeat (10) @(negedge clk_clk);
    reset_reset = 1'b0;
    @(negedge clk_clk);
    check("reset_sdat_oe", 32'(spi_sdat_oe), 32'd0);
    check("reset_sdat_o", 32'(spi_sdat_o), 32'd0);
    check("reset_int", 32'(spi_int), 32'd0);

    read_frame(6'h00, 1'b0, 1);
    read_frame(6'h2C, 1'b1, 12);

    write_frame(6'h2D, 8'h08);
    read_frame(6'h2D, 1'b0, 1);

    do_sample(16'h1234, 16'hFF80, 16'h0100);
    read_frame(6'h30, 1'b0, 1);
    read_frame(6'h32, 1'b1, 6);
    read_frame(6'h30, 1'b0, 1);
    write_frame(6'h32, 8'h55);
    read_frame(6'h32, 1'b0, 1);

    read_frame(6'h32, 1'b1, 6, 12, 16'hAAAA, 16'h5555, 16'h0F0F);
    read_frame(6'h30, 1'b0, 1);
    read_frame(6'h32, 1'b1, 2);

    write_frame(6'h2E, 8'h80);
    do_sample(16'h0011, 16'h2233, 16'h4455);
    read_frame(6'h32, 1'b1, 6);
    write_frame(6'h31, 8'h20);
    do_sample(16'h6677, 16'h8899, 16'hAABB);
    read_frame(6'h36, 1'b1, 2);

    write_frame(6'h2D, 8'hFF, 5);
    read_frame(6'h2D, 1'b0, 1);
    spi_cs_n = 1'b0;
    cmd_phase = 1'b1;
    half_p();
    send_bits({2'b00, 6'h2C}, 4);
    cmd_phase = 1'b0;
    end_frame();
    read_frame(6'h2C, 1'b1, 3);

    read_frame(6'h3F, 1'b1, 2);
    read_frame(6'h00, 1'b0, 3);

    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 3);
      case (op)
        0: do_sample(16'($urandom()), 16'($urandom()), 16'($urandom()));
        1: begin
          nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8;
          write_frame(wa_list[$urandom_range(0, 6)], 8'($urandom()), nb);
        end
        2: begin
          ra = 6'($urandom_range(0, 63));
          read_frame(ra, 1'($urandom_range(0, 1)), $urandom_range(1, 3));
        end
        default: begin
          ra = 6'h32 + 6'($urandom_range(0, 5));
          n = $urandom_range(1, 4);
          read_frame(ra, 1'b1, n, $urandom_range(0, n * 8 - 1),
                     16'($urandom()), 16'($urandom()), 16'($urandom()));
        end
      endcase
    end

    spi_cs_n = 1'b0;
    half_p();
    send_bits(8'h80, 8);
    for (int b = 0; b < 3; b++) begin
      spi_sclk = 1'b0; half_p(); spi_sclk = 1'b1; half_p();
    end
    @(negedge clk_clk);
    reset_reset = 1'b1;
    @(negedge clk_clk);
    reset_reset = 1'b0;
    m_reset();
    check("oe_after_midframe_reset", 32'(spi_sdat_oe), 32'd0);
    check("sdat_o_after_midframe_reset", 32'(spi_sdat_o), 32'd0);
    cmd_phase = 1'b1;
    for (int b = 0; b < 5; b++) begin
      spi_sclk = 1'b0; half_p(); spi_sclk = 1'b1; half_p();
    end
    send_bits(8'h80, 8);
    send_bits(8'h00, 8);
    cmd_phase = 1'b0;
    end_frame();
    read_frame(6'h00, 1'b0, 1);
    read_frame(6'h2C, 1'b1, 12);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
